// File: rtl/tap_controller_if.sv
// Pin-level bundle between the TAP front end and its environment (tester pins + BIST block).
interface tap_controller_if #(parameter int DR_W = 10);
  logic            TMS;
  logic            TDI;
  logic            TDO;
  logic            TDO_EN;
  logic [7:0]      BIST_DATA;
  logic            TLR;
  logic            UPDATEDR;
  logic            RUNBIST_SELECT;
  logic            GETTEST_SELECT;
  logic            SETSTATE_SELECT;
  logic [DR_W-1:0] BSR;

  modport master (
    output TMS, TDI, BIST_DATA,
    input  TDO, TDO_EN, TLR, UPDATEDR, RUNBIST_SELECT, GETTEST_SELECT, SETSTATE_SELECT, BSR
  );

  modport slave (
    input  TMS, TDI, BIST_DATA,
    output TDO, TDO_EN, TLR, UPDATEDR, RUNBIST_SELECT, GETTEST_SELECT, SETSTATE_SELECT, BSR
  );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP front end: 16-state FSM, instruction register and the shared
// BIST data register, with IDCODE and BYPASS registers on the same serial path.
module tap_controller #(
  parameter int          IR_W   = 4,
  parameter int          DR_W   = 10,
  parameter logic [31:0] IDCODE = 32'h1000_0001
) (
  input  logic            TCK,
  input  logic            TRST,
  tap_controller_if.slave tap
);

  typedef enum logic [3:0] {
    ST_TLR, ST_RTI, ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR, ST_PAUSE_DR, ST_EX2_DR,
    ST_UPD_DR, ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR, ST_PAUSE_IR, ST_EX2_IR, ST_UPD_IR
  } state_t;

  typedef enum logic [2:0] {K_BYPASS, K_IDCODE, K_GETTEST, K_RUNBIST, K_SETSTATE} kind_t;

  localparam logic [IR_W-1:0] OP_IDCODE   = IR_W'(4'b0001);
  localparam logic [IR_W-1:0] OP_GETTEST  = IR_W'(4'b0010);
  localparam logic [IR_W-1:0] OP_RUNBIST  = IR_W'(4'b0011);
  localparam logic [IR_W-1:0] OP_SETSTATE = IR_W'(4'b0100);
  localparam logic [IR_W-1:0] IR_CAPTURE  = IR_W'(4'b0101);

  // Unlisted opcodes (including 1111) all fall through to BYPASS.
  function automatic kind_t decode(input logic [IR_W-1:0] ir);
    kind_t k;
    case (ir)
      OP_IDCODE:   k = K_IDCODE;
      OP_GETTEST:  k = K_GETTEST;
      OP_RUNBIST:  k = K_RUNBIST;
      OP_SETSTATE: k = K_SETSTATE;
      default:     k = K_BYPASS;
    endcase
    return k;
  endfunction

  // Select vector ordered {runbist, gettest, setstate}.
  function automatic logic [2:0] select_bits(input kind_t k);
    return {k == K_RUNBIST, k == K_GETTEST, k == K_SETSTATE};
  endfunction

  state_t            state_r, state_next_s;
  logic [IR_W-1:0]   ir_shift_r, ir_active_r, ir_active_next_s;
  logic [DR_W-1:0]   dr_r;
  logic [31:0]       id_r;
  logic              byp_r;
  logic [2:0]        sel_r;
  logic              tdo_s;
  kind_t             active_kind_s;

  assign active_kind_s = decode(ir_active_r);

  // TAP state register.
  always_ff @(posedge TCK) begin
    if (TRST) state_r <= ST_TLR;
    else      state_r <= state_next_s;
  end

  // TMS-driven state transitions.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_TLR:      state_next_s = tap.TMS ? ST_TLR    : ST_RTI;
      ST_RTI:      state_next_s = tap.TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR:   state_next_s = tap.TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR:   state_next_s = tap.TMS ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:    state_next_s = tap.TMS ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR:   state_next_s = tap.TMS ? ST_UPD_DR : ST_PAUSE_DR;
      ST_PAUSE_DR: state_next_s = tap.TMS ? ST_EX2_DR : ST_PAUSE_DR;
      ST_EX2_DR:   state_next_s = tap.TMS ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR:   state_next_s = tap.TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR:   state_next_s = tap.TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR:   state_next_s = tap.TMS ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:    state_next_s = tap.TMS ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR:   state_next_s = tap.TMS ? ST_UPD_IR : ST_PAUSE_IR;
      ST_PAUSE_IR: state_next_s = tap.TMS ? ST_EX2_IR : ST_PAUSE_IR;
      ST_EX2_IR:   state_next_s = tap.TMS ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR:   state_next_s = tap.TMS ? ST_SEL_DR : ST_RTI;
      default:     state_next_s = ST_TLR;
    endcase
  end

  // Next active instruction; shared by the IR register and the select decode.
  always_comb begin
    ir_active_next_s = ir_active_r;
    case (state_r)
      ST_UPD_IR: ir_active_next_s = ir_shift_r;
      ST_TLR:    ir_active_next_s = OP_IDCODE;
      default:   ir_active_next_s = ir_active_r;
    endcase
  end

  // Instruction shift and active registers.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      ir_shift_r  <= '0;
      ir_active_r <= OP_IDCODE;
    end else begin
      ir_active_r <= ir_active_next_s;
      case (state_r)
        ST_CAP_IR: ir_shift_r <= IR_CAPTURE;
        ST_SH_IR:  ir_shift_r <= {tap.TDI, ir_shift_r[IR_W-1:1]};
        default:   ir_shift_r <= ir_shift_r;
      endcase
    end
  end

  // Selects are registered from the next IR so they track UpdIR one cycle later.
  always_ff @(posedge TCK) begin
    if (TRST)                        sel_r <= 3'b000;
    else if (state_next_s == ST_TLR) sel_r <= 3'b000;
    else                             sel_r <= select_bits(decode(ir_active_next_s));
  end

  // Data-side capture and shift; pause/exit states simply hold.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      dr_r  <= '0;
      id_r  <= 32'h0000_0000;
      byp_r <= 1'b0;
    end else if (state_r == ST_CAP_DR) begin
      case (active_kind_s)
        K_RUNBIST: dr_r  <= {{(DR_W-8){1'b0}}, tap.BIST_DATA};
        K_IDCODE:  id_r  <= IDCODE;
        K_BYPASS:  byp_r <= 1'b0;
        default:   dr_r  <= dr_r;
      endcase
    end else if (state_r == ST_SH_DR) begin
      case (active_kind_s)
        K_IDCODE: id_r  <= {tap.TDI, id_r[31:1]};
        K_BYPASS: byp_r <= tap.TDI;
        default:  dr_r  <= {tap.TDI, dr_r[DR_W-1:1]};
      endcase
    end
  end

  // Serial output mux: LSB of whichever register is on the scan path.
  always_comb begin
    tdo_s = 1'b0;
    if (state_r == ST_SH_IR) begin
      tdo_s = ir_shift_r[0];
    end else if (state_r == ST_SH_DR) begin
      case (active_kind_s)
        K_IDCODE: tdo_s = id_r[0];
        K_BYPASS: tdo_s = byp_r;
        default:  tdo_s = dr_r[0];
      endcase
    end else begin
      tdo_s = 1'b0;
    end
  end

  assign tap.TDO             = tdo_s;
  assign tap.TDO_EN          = (state_r == ST_SH_IR) || (state_r == ST_SH_DR);
  assign tap.TLR             = (state_r == ST_TLR);
  assign tap.UPDATEDR        = (state_r == ST_UPD_DR);
  assign tap.RUNBIST_SELECT  = sel_r[2];
  assign tap.GETTEST_SELECT  = sel_r[1];
  assign tap.SETSTATE_SELECT = sel_r[0];
  assign tap.BSR             = dr_r;

endmodule

// File: tb/tb_tap_controller.sv
// Scoreboard bench for tap_controller: directed TAP sequences plus a random TMS/TDI walk,
// checked against a table-driven reference model.
module tb_tap_controller;
  localparam logic [31:0] IDCODE_VAL = 32'h1000_0001;

  // Output vector layout: {TLR, UPDATEDR, TDO_EN, TDO, RUNBIST, GETTEST, SETSTATE, BSR[9:0]}
  localparam logic [16:0] B_TLR = 17'h10000;
  localparam logic [16:0] B_UPD = 17'h08000;
  localparam logic [16:0] B_EN  = 17'h04000;
  localparam logic [16:0] B_TDO = 17'h02000;
  localparam logic [16:0] B_GET = 17'h00800;
  localparam logic [16:0] B_SEL = 17'h01C00;
  localparam logic [16:0] B_BSR = 17'h003FF;

  localparam int M_TLR = 0, M_CAPDR = 3, M_SHDR = 4, M_UPDDR = 8;
  localparam int M_CAPIR = 10, M_SHIR = 11, M_UPDIR = 15;

  // next state indexed [state][tms]
  int nxt [16][2] = '{
    '{1, 0},  '{1, 2},  '{3, 9},   '{4, 5},   '{4, 5},   '{6, 8},   '{6, 7},   '{4, 8},
    '{1, 2},  '{10, 0}, '{11, 12}, '{11, 12}, '{13, 15}, '{13, 14}, '{11, 15}, '{1, 2}
  };

  typedef struct {
    logic [16:0] exp;
    logic [16:0] dmask;
    logic [16:0] dval;
    string       dname;
  } entry_t;

  logic clk = 1'b0;
  logic trst = 1'b1;
  logic [7:0] bist = 8'h00;
  always #5 clk = ~clk;

  tap_controller_if #(.DR_W(10)) tap();

  tap_controller #(.IR_W(4), .DR_W(10), .IDCODE(IDCODE_VAL)) dut (
    .TCK (clk),
    .TRST(trst),
    .tap (tap)
  );

  entry_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model state
  int         ms = 0;
  bit         known = 1'b0;
  logic [3:0] mirs, mira;
  logic [9:0] mdr;
  logic [31:0] mid;
  logic       mbyp;

  // 1=IDCODE 2=GETTEST 3=RUNBIST 4=SETSTATE 0=BYPASS
  function automatic int kind(input logic [3:0] ir);
    if (ir >= 4'd1 && ir <= 4'd4) return int'(ir);
    return 0;
  endfunction

  function automatic logic [16:0] model_out();
    int k;
    logic t;
    logic [2:0] sel;
    k = kind(mira);
    if (ms == M_SHIR)      t = mirs[0];
    else if (ms == M_SHDR) t = (k == 1) ? mid[0] : (k == 0) ? mbyp : mdr[0];
    else                   t = 1'b0;
    sel = (ms == M_TLR) ? 3'b000 : {k == 3, k == 2, k == 4};
    return {ms == M_TLR, ms == M_UPDDR, (ms == M_SHDR) || (ms == M_SHIR), t, sel, mdr};
  endfunction

  task automatic model_edge(input bit tms, input bit tdi, input bit rst, input logic [7:0] bd);
    int k;
    if (rst) begin
      ms = M_TLR; mirs = 4'd0; mira = 4'd1; mdr = 10'd0; mid = 32'd0; mbyp = 1'b0;
      known = 1'b1;
    end else begin
      k = kind(mira);
      if (ms == M_CAPIR) mirs = 4'b0101;
      if (ms == M_SHIR)  mirs = (mirs >> 1) | (tdi ? 4'b1000 : 4'b0000);
      if (ms == M_UPDIR) mira = mirs;
      if (ms == M_TLR)   mira = 4'd1;
      if (ms == M_CAPDR) begin
        if (k == 3)      mdr  = {2'b00, bd};
        else if (k == 1) mid  = IDCODE_VAL;
        else if (k == 0) mbyp = 1'b0;
      end
      if (ms == M_SHDR) begin
        if (k == 1)      mid  = (mid >> 1) | (tdi ? 32'h8000_0000 : 32'h0);
        else if (k == 0) mbyp = tdi;
        else             mdr  = (mdr >> 1) | (tdi ? 10'h200 : 10'h000);
      end
      ms = nxt[ms][tms];
    end
  endtask

  task automatic step(input bit tms, input bit tdi, input bit rst);
    entry_t e;
    @(posedge clk);
    #1;
    tap.TMS = tms; tap.TDI = tdi; tap.BIST_DATA = bist; trst = rst;
    if (known) begin
      e.exp = model_out(); e.dmask = 17'h0; e.dval = 17'h0; e.dname = "";
      exp_q.push_back(e);
    end
    model_edge(tms, tdi, rst, bist);
  endtask

  // attach a directed constant expectation to the cycle just issued
  task automatic expect_dir(input logic [16:0] mask, input logic [16:0] val, input string nm);
    entry_t e;
    e = exp_q.pop_back();
    e.dmask = mask; e.dval = val; e.dname = nm;
    exp_q.push_back(e);
  endtask

  task automatic load_ir(input logic [3:0] op);
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, op[i], 1'b0);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
  endtask

  // From RTI: capture, shift n bits, exit and finish with the UpdDR cycle just issued
  task automatic shift_dr(input int n, input logic [31:0] din, input logic [31:0] dexp,
                          input bit chk, input string nm);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], 1'b0);
      if (chk) expect_dir(B_TDO | B_EN, B_EN | (dexp[i] ? B_TDO : 17'h0), nm);
    end
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every issued cycle is compared against the model, plus any directed constant.
  always @(negedge clk) begin
    entry_t e;
    logic [16:0] act;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {tap.TLR, tap.UPDATEDR, tap.TDO_EN, tap.TDO, tap.RUNBIST_SELECT,
             tap.GETTEST_SELECT, tap.SETSTATE_SELECT, tap.BSR};
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL model_outputs cycle=%0d actual=%h required=%h", cyc, act, e.exp);
      end
      if (e.dmask != 17'h0) begin
        n_tests++;
        if ((act & e.dmask) !== (e.dval & e.dmask)) begin
          n_fail++;
          $display("FAIL %s cycle=%0d actual=%h required=%h", e.dname, cyc,
                   act & e.dmask, e.dval & e.dmask);
        end
      end
    end
  end

  initial begin
    tap.TMS = 1'b1; tap.TDI = 1'b0; tap.BIST_DATA = 8'h00;
    // reset, then five TMS=1 clocks
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    expect_dir(17'h1FFFF, B_TLR, "reset_state");
    repeat (4) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    expect_dir(B_TLR | B_SEL | B_BSR, B_TLR, "t1_tlr");
    step(1'b0, 1'b0, 1'b0);
    expect_dir(B_TLR, 17'h0, "t1_rti");

    shift_dr(32, $urandom, IDCODE_VAL, 1'b1, "t2_idcode");

    load_ir(4'b0010);
    shift_dr(10, 32'h0000_0298, 32'h0, 1'b0, "");
    expect_dir(B_UPD | B_BSR | B_SEL, B_UPD | B_GET | 17'h00298, "t3_gettest_update");

    bist = 8'hA5;
    load_ir(4'b0011);
    shift_dr(10, $urandom, 32'h0000_00A5, 1'b1, "t4_runbist");

    load_ir(4'b1010);
    shift_dr(3, 32'h0000_0005, 32'h0000_0002, 1'b1, "t5_bypass");

    load_ir(4'b0100);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    expect_dir(B_TLR | B_UPD | B_BSR | B_SEL, B_TLR, "t6_abort");

    repeat (3000) begin
      bist = 8'($urandom);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 127) == 0);
    end
    step(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
